mem_copy_engine: RTL
====================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter WIDTH, default 32: data word width, matches the attached RAM.
REQ-002 Parameter ADDR_WIDTH, default 10: word-address width, matches the attached RAM.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle command strobe, sampled only in IDLE.
REQ-006 op  input  1  0 = copy, 1 = fill.
REQ-007 src  input  ADDR_WIDTH  copy source start word address; ignored for fill.
REQ-008 dst  input  ADDR_WIDTH  destination start word address.
REQ-009 len  input  ADDR_WIDTH+1  word count, 0 to 2^ADDR_WIDTH.
REQ-010 fill_value  input  WIDTH  data written by fill.
REQ-011 busy  output  1  high while a transfer is in progress.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 mem_write  output  1  RAM write enable.
REQ-014 mem_addr  output  ADDR_WIDTH  RAM word address.
REQ-015 mem_wdata  output  WIDTH  RAM write data.
REQ-016 mem_rdata  input  WIDTH  RAM read data; combinational from mem_addr in the same cycle.

Function
REQ-017 The block SHALL implement FSM states IDLE, RD, WR, FILL, DONE.
REQ-018 In IDLE, start=1 at a clock edge SHALL latch src, dst, len, op and fill_value into internal registers and go to DONE if len=0, else to FILL if op=1, else to RD.
REQ-019 RD SHALL drive mem_addr=src_ptr, mem_write=0, capture mem_rdata into a WIDTH-bit buffer at the edge, and go to WR.
REQ-020 WR SHALL drive mem_addr=dst_ptr, mem_wdata=buffer, mem_write=1; at the edge it SHALL increment both pointers, decrement the remaining count, and go to DONE if the remaining count was 1, else to RD.
REQ-021 FILL SHALL drive mem_addr=dst_ptr, mem_wdata=fill register, mem_write=1; at the edge it SHALL increment dst_ptr, decrement the remaining count, and go to DONE if the remaining count was 1, else stay in FILL.
REQ-022 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-023 busy SHALL be 1 in RD, WR and FILL, and 0 in IDLE and DONE.
REQ-024 Throughput SHALL be 2 cycles per word for copy and 1 cycle per word for fill; done SHALL assert in cycle 2*len+1 (copy) or len+1 (fill) after the start edge, and in cycle 1 when len=0.
REQ-025 Pointers SHALL wrap modulo 2^ADDR_WIDTH (address 2^ADDR_WIDTH-1 is followed by 0).
REQ-026 len=2^ADDR_WIDTH SHALL transfer the whole address space exactly once.
REQ-027 Copy SHALL always proceed in ascending address order; for overlapping regions with dst>src, words already overwritten are re-read (defined forward-copy semantics, no hazard detection).
REQ-028 start SHALL be ignored in every state other than IDLE, and input changes after the start edge SHALL have no effect on the transfer in progress.
REQ-029 Outside WR and FILL, mem_write SHALL be 0; mem_addr and mem_wdata are don't-care when mem_write=0, except in RD.
REQ-030 At most one RAM write SHALL occur per cycle, and a word SHALL never be written twice within one fill.

Reset
REQ-031 reset=1 at a clock edge SHALL force IDLE, with busy=0, done=0, mem_write=0, mem_addr=0, mem_wdata=0, and pointers, count and buffer cleared.
REQ-032 reset SHALL take priority over start and SHALL abort a transfer mid-operation with no further RAM write after the reset edge; words already written remain.

Verification
REQ-033 Copy: RAM[0x010..0x012]=0xA,0xB,0xC; start op=0 src=0x010 dst=0x100 len=3 -> RAM[0x100..0x102]=0xA,0xB,0xC, exactly 3 write cycles, done high in cycle 7 after start, busy high in cycles 1-6.
REQ-034 Fill with wrap: op=1 dst=0x3FE len=4 fill_value=0xDEADBEEF -> addresses 0x3FE, 0x3FF, 0x000, 0x001 written in that order, done in cycle 5.
REQ-035 len=0: start -> no mem_write at any time, done in cycle 1, busy never high.
REQ-036 Start while busy: a second start with different src/dst/len during the REQ-033 copy -> ignored; results and timing identical to REQ-033.
REQ-037 Reset mid-copy: len=8 copy, reset asserted in cycle 5 -> mem_write=0 from the reset edge onward, only the first 2 destination words are written, state IDLE, and a new fill started afterwards completes normally.
REQ-038 Overlap: RAM[0..3]=1,2,3,4; copy src=0 dst=1 len=3 -> RAM[0..3]=1,1,1,1.

Source files
------------

// File: rtl/mem_copy_engine.sv
// Word-at-a-time RAM copy/fill engine: copy reads then writes each word (2 cycles/word),
// fill writes a latched constant (1 cycle/word); pointers wrap across the address space.
module mem_copy_engine #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  op,
    input  logic [ADDR_WIDTH-1:0] src,
    input  logic [ADDR_WIDTH-1:0] dst,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic [WIDTH-1:0]      fill_value,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, WR, FILL, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] src_ptr, dst_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [WIDTH-1:0]      buffer, fill_reg;
    logic                  last;

    // count is one bit wider than the pointers so a full-space transfer is representable
    assign last = (count == CNT_ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0)
                        state_next = DONE;
                    else if (op)
                        state_next = FILL;
                    else
                        state_next = RD;
                end
            end
            RD:      state_next = WR;
            WR:      state_next = last ? DONE : RD;
            FILL:    state_next = last ? DONE : FILL;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_ptr  <= '0;
            dst_ptr  <= '0;
            count    <= '0;
            buffer   <= '0;
            fill_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr  <= src;
                        dst_ptr  <= dst;
                        count    <= len;
                        fill_reg <= fill_value;
                    end
                end
                RD: buffer <= mem_rdata;
                WR: begin
                    src_ptr <= src_ptr + PTR_ONE;
                    dst_ptr <= dst_ptr + PTR_ONE;
                    count   <= count - CNT_ONE;
                end
                FILL: begin
                    dst_ptr <= dst_ptr + PTR_ONE;
                    count   <= count - CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            RD: begin
                busy     = 1'b1;
                mem_addr = src_ptr;
            end
            WR: begin
                busy      = 1'b1;
                mem_write = 1'b1;
                mem_addr  = dst_ptr;
                mem_wdata = buffer;
            end
            FILL: begin
                busy      = 1'b1;
                mem_write = 1'b1;
                mem_addr  = dst_ptr;
                mem_wdata = fill_reg;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule
